// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Radix-2 shift-add multiplier, one partial product per clock, WIDTH clocks
//   per operation. Signed operands are reduced to magnitudes on accept and the
//   product is negated on the way into y when the operand signs differ.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin a multiply (accepted in IDLE or DONE)
//   a, b         operands, captured on accept
//   signed_mode  1 = two's-complement operands, captured on accept
//   busy         high while the multiply is running
//   done         one-cycle pulse, y holds a new result
//   y            2*WIDTH-bit product register
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start, y holds the last result
// S_BUSY | one add/shift per clock, counter counts WIDTH down to 1
// S_DONE | done pulse; start here chains straight into S_BUSY
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   y
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic            neg;

    logic            accept;
    logic            cnt_tc;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]   acc_nxt;

    // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits in WIDTH
    // unsigned bits, so the negation below is exact for every operand.
    assign mag_a   = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign mag_b   = (signed_mode && b[WIDTH-1]) ? -b : b;

    assign accept  = start && (state != S_BUSY);
    assign cnt_tc  = (cnt == CW'(1));
    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

    assign busy    = (state == S_BUSY);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_BUSY;
            S_BUSY:  if (cnt_tc) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_BUSY : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            y      <= '0;
        end else if (accept) begin
            cnt    <= CW'(WIDTH);
            acc    <= '0;
            mcand  <= PW'(mag_a);
            mplier <= mag_b;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state == S_BUSY) begin
            cnt    <= cnt - 1'b1;
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            // Final partial product folds straight into y on the DONE entry edge.
            if (cnt_tc) begin
                y <= neg ? -acc_nxt : acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier
//   Directed and swept checks of seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

    logic       clk;
    logic       rst;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       sm4;
    logic       busy4;
    logic       done4;
    logic [7:0] y4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       sm8;
    logic       busy8;
    logic       done8;
    logic [15:0] y8;

    int n_assert = 0;
    int n_fail   = 0;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start4),
        .a           (a4),
        .b           (b4),
        .signed_mode (sm4),
        .busy        (busy4),
        .done        (done4),
        .y           (y4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .a           (a8),
        .b           (b8),
        .signed_mode (sm8),
        .busy        (busy8),
        .done        (done8),
        .y           (y8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] z, input logic sm);
        int sx;
        int sz;
        int p;
        sx = (sm && x[3]) ? int'(x) - 16 : int'(x);
        sz = (sm && z[3]) ? int'(z) - 16 : int'(z);
        p  = sx * sz;
        return p[7:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] z, input logic sm);
        int sx;
        int sz;
        int p;
        sx = (sm && x[7]) ? int'(x) - 256 : int'(x);
        sz = (sm && z[7]) ? int'(z) - 256 : int'(z);
        p  = sx * sz;
        return p[15:0];
    endfunction

    // Accept edge, then count edges until done; done must follow WIDTH edges later.
    task automatic mul4(input logic [3:0] ia, input logic [3:0] ib, input logic ism,
                        input logic [7:0] exp, input string tag);
        int lat;
        a4 = ia; b4 = ib; sm4 = ism; start4 = 1'b1;
        step();
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " y"}, 64'(y4), 64'(exp));
    endtask

    task automatic mul8(input logic [7:0] ia, input logic [7:0] ib, input logic ism,
                        input logic [15:0] exp, input string tag);
        int lat;
        a8 = ia; b8 = ib; sm8 = ism; start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 30) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " y"}, 64'(y8), 64'(exp));
    endtask

    initial begin
        int n;
        int ndone;

        rst = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset busy", 64'(busy4), 64'd0);
        check("reset done", 64'(done4), 64'd0);
        check("reset y", 64'(y4), 64'd0);
        check("reset y8", 64'(y8), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 15*15 unsigned: busy for exactly 4 cycles, single done pulse
        a4 = 4'd15; b4 = 4'd15; sm4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("15x15 y held during busy", 64'(y4), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("15x15 busy cyc%0d", k), 64'(busy4), 64'd1);
            check($sformatf("15x15 no done cyc%0d", k), 64'(done4), 64'd0);
            step();
        end
        check("15x15 done", 64'(done4), 64'd1);
        check("15x15 busy low", 64'(busy4), 64'd0);
        check("15x15 y", 64'(y4), 64'hE1);
        step();
        check("15x15 done one cycle", 64'(done4), 64'd0);
        check("15x15 idle busy", 64'(busy4), 64'd0);
        check("15x15 y held in idle", 64'(y4), 64'hE1);

        // Boundary operand -8
        mul4(4'b1000, 4'b1000, 1'b1, 8'h40, "s -8x-8");
        mul4(4'b1000, 4'b1000, 1'b0, 8'h40, "u 8x8");
        mul4(4'b1000, 4'b0111, 1'b1, 8'hC8, "s -8x7");
        mul4(4'b1000, 4'b0111, 1'b0, 8'h38, "u 8x7");
        mul4(4'b0111, 4'b1111, 1'b1, 8'hF9, "s 7x-1");
        mul4(4'b0000, 4'b1001, 1'b1, 8'h00, "s 0x-7");
        step();

        // start held across two operations, operands changed mid-BUSY
        a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0; start4 = 1'b1;
        step();
        a4 = 4'd2; b4 = 4'd6;
        n = 0;
        while (!done4 && n < 20) begin
            step();
            n++;
        end
        check("b2b first latency", 64'(n), 64'd4);
        check("b2b first y", 64'(y4), 64'd15);
        step();
        check("b2b no idle gap", 64'(busy4), 64'd1);
        check("b2b y held in busy", 64'(y4), 64'd15);
        a4 = 4'd7; b4 = 4'd7; start4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            step();
            n++;
        end
        check("b2b done spacing", 64'(n), 64'd5);
        check("b2b second y", 64'(y4), 64'd12);
        step();

        // Async reset in the 2nd BUSY cycle aborts without a done pulse
        a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        check("pre-abort busy", 64'(busy4), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 64'(busy4), 64'd0);
        check("abort done", 64'(done4), 64'd0);
        check("abort y", 64'(y4), 64'd0);
        #1 rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done4) ndone++;
        end
        check("no done after abort", 64'(ndone), 64'd0);
        mul4(4'd9, 4'd9, 1'b0, 8'h51, "9x9 after reset");
        step();

        // Exhaustive WIDTH=4
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    mul4(4'(i), 4'(j), 1'(m), ref4(4'(i), 4'(j), 1'(m)),
                         $sformatf("sweep4 m%0d %0dx%0d", m, i, j));
                end
            end
        end

        // WIDTH=8 directed corners then random
        mul8(8'h80, 8'h80, 1'b1, 16'h4000, "s8 -128x-128");
        mul8(8'h80, 8'h7F, 1'b1, 16'hC080, "s8 -128x127");
        mul8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u8 255x255");
        for (int r = 0; r < 120; r++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rm;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            mul8(ra, rb, rm, ref8(ra, rb, rm), $sformatf("rand8 m%0d %0hx%0h", rm, ra, rb));
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
